// File: rtl/instr_fetch.sv
// Instruction fetch stage: owns the PC, drives the req/ack instruction-memory port and holds
// the IF/ID register, with a one-entry skid buffer for decode stalls and redirect draining.
module instr_fetch #(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
   input  logic        CLK,
   input  logic        RST,
   output logic        IMemReq,
   output logic [31:0] IMemAddr,
   input  logic        IMemAck,
   input  logic [31:0] IMemData,
   input  logic        Stall,
   input  logic        Redirect,
   input  logic [31:0] RedirectPC,
   output logic [31:0] Instr,
   output logic [31:0] PCOut,
   output logic [31:0] PCPlus4,
   output logic        InstrValid,
   output logic [2:0]  ImmControl,
   output logic        IllegalInstr
);

   typedef enum logic [1:0] {StFetch, StFull, StDrain} stateT;

   stateT       state;
   logic [31:0] pc;
   logic [31:0] reqAddr;
   logic [31:0] skidData;
   logic [31:0] skidPc;
   logic [2:0]  skidImm;
   logic        skidIllegal;

   logic [2:0]  dataImm;
   logic        dataIllegal;

   // Returns {illegal, immType} for an opcode.
   function automatic logic [3:0] decodeOp(input logic [6:0] op);
      logic [3:0] res;
      case (op)
         7'b0010011, 7'b0000011, 7'b1100111, 7'b1110011, 7'b0110011: res = 4'b0_000;
         7'b0100011:                                                  res = 4'b0_001;
         7'b1100011:                                                  res = 4'b0_010;
         7'b1101111:                                                  res = 4'b0_011;
         7'b0110111, 7'b0010111:                                      res = 4'b0_100;
         default:                                                     res = 4'b1_000;
      endcase
      return res;
   endfunction

   always_comb begin
      {dataIllegal, dataImm} = decodeOp(IMemData[6:0]);
      IMemReq  = (state != StFull);
      IMemAddr = (state == StDrain) ? reqAddr : pc;
      PCPlus4  = PCOut + 32'd4;
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state        <= StFetch;
         pc           <= RESET_PC;
         reqAddr      <= RESET_PC;
         Instr        <= NOP_INSTR;
         PCOut        <= RESET_PC;
         ImmControl   <= 3'b000;
         IllegalInstr <= 1'b0;
         InstrValid   <= 1'b0;
         skidData     <= NOP_INSTR;
         skidPc       <= RESET_PC;
         skidImm      <= 3'b000;
         skidIllegal  <= 1'b0;
      end else if (Redirect) begin
         pc           <= RedirectPC;
         InstrValid   <= 1'b0;
         Instr        <= NOP_INSTR;
         ImmControl   <= 3'b000;
         IllegalInstr <= 1'b0;
         // A request still in flight must be completed and thrown away before refetching.
         if ((state == StFetch || state == StDrain) && !IMemAck) state <= StDrain;
         else                                                    state <= StFetch;
         if (state == StFetch) reqAddr <= pc;
      end else begin
         case (state)
            StFetch: begin
               if (IMemAck) begin
                  pc <= pc + 32'd4;
                  if (!InstrValid || !Stall) begin
                     Instr        <= IMemData;
                     PCOut        <= pc;
                     ImmControl   <= dataImm;
                     IllegalInstr <= dataIllegal;
                     InstrValid   <= 1'b1;
                  end else begin
                     skidData    <= IMemData;
                     skidPc      <= pc;
                     skidImm     <= dataImm;
                     skidIllegal <= dataIllegal;
                     state       <= StFull;
                  end
               end else if (!Stall) begin
                  InstrValid   <= 1'b0;
                  Instr        <= NOP_INSTR;
                  ImmControl   <= 3'b000;
                  IllegalInstr <= 1'b0;
               end
            end
            StFull: begin
               if (!Stall) begin
                  Instr        <= skidData;
                  PCOut        <= skidPc;
                  ImmControl   <= skidImm;
                  IllegalInstr <= skidIllegal;
                  InstrValid   <= 1'b1;
                  state        <= StFetch;
               end
            end
            StDrain: begin
               if (IMemAck) state <= StFetch;
            end
            default: state <= StFetch;
         endcase
      end
   end

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: decode/stream vector table plus hand-written wait-state,
// stall, redirect and PC-wrap sequences against a latency-programmable memory model.
module tb_instr_fetch;

   logic        CLK;
   logic        RST;
   logic        IMemReq;
   logic [31:0] IMemAddr;
   logic        IMemAck;
   logic [31:0] IMemData;
   logic        Stall;
   logic        Redirect;
   logic [31:0] RedirectPC;
   logic [31:0] Instr;
   logic [31:0] PCOut;
   logic [31:0] PCPlus4;
   logic        InstrValid;
   logic [2:0]  ImmControl;
   logic        IllegalInstr;

   int errors = 0;
   int checks = 0;

   logic [31:0] mem [128];
   int unsigned latency;
   int unsigned ackCnt;

   localparam logic [31:0] Nop = 32'h0000_0013;

   instr_fetch dut (
      .CLK(CLK), .RST(RST), .IMemReq(IMemReq), .IMemAddr(IMemAddr), .IMemAck(IMemAck),
      .IMemData(IMemData), .Stall(Stall), .Redirect(Redirect), .RedirectPC(RedirectPC),
      .Instr(Instr), .PCOut(PCOut), .PCPlus4(PCPlus4), .InstrValid(InstrValid),
      .ImmControl(ImmControl), .IllegalInstr(IllegalInstr)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   // Memory: acks once the request has been waiting `latency` cycles (0 = same cycle).
   assign IMemAck  = IMemReq && (ackCnt >= latency);
   assign IMemData = mem[IMemAddr[8:2]];

   always @(posedge CLK or posedge RST) begin
      if (RST)                      ackCnt <= 0;
      else if (IMemReq && IMemAck)  ackCnt <= 0;
      else if (IMemReq)             ackCnt <= ackCnt + 1;
   end

   typedef struct {
      logic [31:0] word;
      logic [2:0]  imm;
      logic        ill;
   } vecT;

   vecT vec [7];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   task automatic doReset();
      #1 RST = 1'b1;
      @(posedge CLK);
      #1 RST = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      vec[0] = '{32'h0050_0093, 3'b000, 1'b0};
      vec[1] = '{32'h0011_2223, 3'b001, 1'b0};
      vec[2] = '{32'h0020_8463, 3'b010, 1'b0};
      vec[3] = '{32'h0080_00EF, 3'b011, 1'b0};
      vec[4] = '{32'h1234_5037, 3'b100, 1'b0};
      vec[5] = '{32'h0000_007F, 3'b000, 1'b1};
      vec[6] = '{32'h0020_81B3, 3'b000, 1'b0};
      for (int i = 0; i < 128; i++) mem[i] = (32'(i) << 20) | 32'h13;
      for (int i = 0; i < 7; i++) mem[i] = vec[i].word;

      RST = 1'b1; Stall = 1'b0; Redirect = 1'b0; RedirectPC = '0; latency = 0;
      #2;
      chk("rst_instr", Instr, Nop);
      chk("rst_valid", {31'b0, InstrValid}, 0);
      chk("rst_pcout", PCOut, 0);
      chk("rst_pcplus4", PCPlus4, 4);
      chk("rst_imm", {29'b0, ImmControl}, 0);
      chk("rst_illegal", {31'b0, IllegalInstr}, 0);
      @(posedge CLK);
      #1 RST = 1'b0;
      chk("first_req", {31'b0, IMemReq}, 1);
      chk("first_addr", IMemAddr, 0);

      // Zero-wait stream through the decode table.
      for (int i = 0; i < 7; i++) begin
         step();
         chk($sformatf("vec%0d_valid", i), {31'b0, InstrValid}, 1);
         chk($sformatf("vec%0d_instr", i), Instr, vec[i].word);
         chk($sformatf("vec%0d_pcout", i), PCOut, 32'(i * 4));
         chk($sformatf("vec%0d_pcplus4", i), PCPlus4, 32'(i * 4 + 4));
         chk($sformatf("vec%0d_imm", i), {29'b0, ImmControl}, {29'b0, vec[i].imm});
         chk($sformatf("vec%0d_illegal", i), {31'b0, IllegalInstr}, {31'b0, vec[i].ill});
      end

      // Asynchronous reset mid-cycle.
      #3 RST = 1'b1;
      #1;
      chk("async_instr", Instr, Nop);
      chk("async_valid", {31'b0, InstrValid}, 0);
      chk("async_pcout", PCOut, 0);
      chk("async_imm", {29'b0, ImmControl}, 0);
      @(posedge CLK);
      #1 RST = 1'b0;
      chk("rel_req", {31'b0, IMemReq}, 1);
      chk("rel_addr", IMemAddr, 0);

      // Wait-state memory on the 0x4 fetch.
      step();
      chk("ws_first_pc", PCOut, 0);
      latency = 3;
      for (int k = 0; k < 3; k++) begin
         step();
         chk($sformatf("ws%0d_addr", k), IMemAddr, 32'h4);
         chk($sformatf("ws%0d_req", k), {31'b0, IMemReq}, 1);
         chk($sformatf("ws%0d_valid", k), {31'b0, InstrValid}, 0);
         chk($sformatf("ws%0d_instr", k), Instr, Nop);
      end
      step();
      chk("ws_valid", {31'b0, InstrValid}, 1);
      chk("ws_instr", Instr, 32'h0011_2223);
      chk("ws_pcout", PCOut, 32'h4);
      step();
      chk("ws_single", {31'b0, InstrValid}, 0);

      // Stall while 0x8 is acked: skid absorbs it.
      latency = 0;
      doReset();
      step();
      step();
      chk("st_pre_pc", PCOut, 32'h4);
      Stall = 1'b1;
      for (int k = 0; k < 4; k++) begin
         step();
         chk($sformatf("st%0d_req", k), {31'b0, IMemReq}, 0);
         chk($sformatf("st%0d_pcout", k), PCOut, 32'h4);
         chk($sformatf("st%0d_instr", k), Instr, mem[1]);
         chk($sformatf("st%0d_valid", k), {31'b0, InstrValid}, 1);
      end
      Stall = 1'b0;
      for (int k = 0; k < 3; k++) begin
         step();
         chk($sformatf("rl%0d_valid", k), {31'b0, InstrValid}, 1);
         chk($sformatf("rl%0d_pcout", k), PCOut, 32'(8 + 4 * k));
         chk($sformatf("rl%0d_instr", k), Instr, mem[2 + k]);
      end

      // Redirect with the 0x8 request outstanding (2-cycle latency).
      doReset();
      step();
      step();
      latency = 2;
      Redirect = 1'b1; RedirectPC = 32'h100;
      step();
      Redirect = 1'b0; RedirectPC = '0;
      chk("dr0_req", {31'b0, IMemReq}, 1);
      chk("dr0_addr", IMemAddr, 32'h8);
      chk("dr0_valid", {31'b0, InstrValid}, 0);
      step();
      chk("dr1_addr", IMemAddr, 32'h8);
      chk("dr1_valid", {31'b0, InstrValid}, 0);
      step();
      chk("dr2_addr", IMemAddr, 32'h100);
      chk("dr2_valid", {31'b0, InstrValid}, 0);
      latency = 0;
      step();
      chk("dr_new_valid", {31'b0, InstrValid}, 1);
      chk("dr_new_pcout", PCOut, 32'h100);
      chk("dr_new_instr", Instr, mem[64]);

      // Redirect coincident with a zero-wait ack of 0x104.
      Redirect = 1'b1; RedirectPC = 32'h40;
      step();
      Redirect = 1'b0;
      chk("co_valid", {31'b0, InstrValid}, 0);
      chk("co_instr", Instr, Nop);
      chk("co_addr", IMemAddr, 32'h40);
      step();
      chk("co_new_valid", {31'b0, InstrValid}, 1);
      chk("co_new_pcout", PCOut, 32'h40);
      chk("co_new_instr", Instr, mem[16]);

      // PC wrap at the top of the address space.
      Redirect = 1'b1; RedirectPC = 32'hFFFF_FFFC;
      step();
      Redirect = 1'b0;
      chk("wr_addr", IMemAddr, 32'hFFFF_FFFC);
      step();
      chk("wr_pcout", PCOut, 32'hFFFF_FFFC);
      chk("wr_pcplus4", PCPlus4, 32'h0);
      chk("wr_instr", Instr, mem[127]);
      step();
      chk("wr2_pcout", PCOut, 32'h0);
      chk("wr2_instr", Instr, mem[0]);
      chk("wr2_pcplus4", PCPlus4, 32'h4);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/instr_fetch.md
# instr_fetch

- Instruction fetch stage of the RISCV32 core.
- Owns the PC and drives a req/ack instruction-memory port.
- Holds the IF/ID register that feeds decode and the immediate extension unit: Instr plus a pre-decoded 3-bit ImmControl.
- Handles decode stalls with a one-entry skid buffer, and handles execute-stage redirects (branch/jump), including discarding an in-flight fetch.

## Interface
- RESET_PC, 32'h00000000, PC value loaded on reset.
- NOP_INSTR, 32'h00000013, Instr value while no valid instruction (addi x0,x0,0).
- CLK  in  1  clock; all state updates on rising edge.
- RST  in  1  reset, asynchronous, active-high.
- IMemReq  out  1  fetch request.
- IMemAddr  out  32  fetch address; stable while IMemReq high and no ack.
- IMemAck  in  1  transfer completes on an edge where IMemReq && IMemAck; may be combinational in the same cycle as IMemReq.
- IMemData  in  32  instruction word, valid with IMemAck.
- Stall  in  1  decode cannot accept a new instruction.
- Redirect  in  1  taken branch/jump; highest priority.
- RedirectPC  in  32  new PC, used when Redirect is high.
- Instr  out  32  IF/ID instruction.
- PCOut  out  32  address of Instr.
- PCPlus4  out  32  PCOut + 4, modulo 2^32.
- InstrValid  out  1  Instr/PCOut/ImmControl are valid.
- ImmControl  out  3  immediate type for the extension unit: I=000, S=001, B=010, J=011, U=100.
- IllegalInstr  out  1  opcode of Instr is not recognised; meaningful only with InstrValid.

## Operation
- Registers:
  - PC: next fetch address.
  - ReqAddr: address of the outstanding request.
  - IF/ID: Instr, PCOut, ImmControl, IllegalInstr, InstrValid.
  - Skid: data, pc, imm, illegal.
  - 2-bit state.
- States and behaviour:
  - FETCH: IMemReq=1, IMemAddr=PC.
    - On ack with the output free (!InstrValid || !Stall): load IF/ID from IMemData/PC; PC <= PC+4.
    - On ack with InstrValid && Stall: load skid; PC <= PC+4; go to FULL.
    - No ack and !Stall: InstrValid <= 0.
  - FULL: IMemReq=0. When !Stall: IF/ID <= skid, InstrValid=1, go to FETCH.
  - DRAIN: IMemReq=1, IMemAddr=ReqAddr (address of the killed request). On ack: discard data, go to FETCH. Otherwise stay.
- Redirect (any state, overrides Stall and ack):
  - PC <= RedirectPC; InstrValid <= 0; skid emptied.
  - Next state:
    - DRAIN if in FETCH with no ack this cycle (request in flight);
    - DRAIN if already in DRAIN with no ack this cycle;
    - else FETCH.
  - Data acked in the same cycle as Redirect is discarded.
- ImmControl/IllegalInstr decode, from opcode bits [6:0], registered together with Instr:
  - 0010011, 0000011, 1100111, 1110011 → 000 (I)
  - 0100011 → 001 (S)
  - 1100011 → 010 (B)
  - 1101111 → 011 (J)
  - 0110111, 0010111 → 100 (U)
  - 0110011 → 000, not illegal
  - anything else → 000, IllegalInstr=1
- PC arithmetic is 32-bit and wraps: 0xFFFFFFFC + 4 = 0x00000000. No alignment check.

## Timing
- Reset values: state=FETCH, PC=RESET_PC, Instr=NOP_INSTR, PCOut=RESET_PC, PCPlus4=RESET_PC+4, InstrValid=0, ImmControl=000, IllegalInstr=0, skid empty.
- IMemReq is high in the first cycle after RST deasserts.
- Fetch-to-output latency: an instruction acked at edge N is visible, with InstrValid=1, after edge N.
- Throughput: one instruction per cycle with zero-wait memory.
- Stall=1 holds all IF/ID outputs stable; at most one further instruction is absorbed (into the skid). No instruction is lost or duplicated.
- Redirect in cycle N: from edge N onward, no instruction older than RedirectPC is presented; the first new IMemAddr=RedirectPC is issued in the cycle after edge N (or after the drain ack).
- RST assertion at any point forces reset values immediately, without waiting for a clock edge. A pending memory transfer is abandoned; the memory model must also be reset.

## Test plan
- Reset: RST pulse mid-stream → immediately Instr=0x00000013, InstrValid=0, PCOut=0, ImmControl=000; after release IMemAddr=0x0 with IMemReq=1.
- Zero-wait stream of 0x00500093, 0x00112223, 0x00208463, 0x008000EF, 0x12345037 → InstrValid high on consecutive cycles; PCOut 0,4,8,C,10; ImmControl 000,001,010,011,100; PCPlus4 = PCOut+4.
- Wait-state memory, ack 3 cycles after req → IMemAddr held at 0x4 for 3 cycles, InstrValid low while stalled for data, then a single valid 0x00112223 with PCOut=0x4.
- Stall=1 for 4 cycles while the word at 0x8 is acked → IF/ID holds the 0x4 instruction, skid holds 0x8, IMemReq=0. On release: 0x8 is presented next cycle, then 0xC; no gaps in PC order, no duplicates.
- Redirect to 0x100 while the 0x8 request is outstanding (2-cycle latency) → DRAIN keeps IMemAddr=0x8 until ack, that data is dropped, next IMemAddr=0x100, first valid PCOut=0x100. Redirect coincident with a zero-wait ack → acked word never shown.
- Word 0x0000007F → InstrValid=1, IllegalInstr=1, ImmControl=000. Word 0x002081B3 (add) → IllegalInstr=0, ImmControl=000.
